// File: rtl/fifo_sw_pkg.sv
// Shared definitions for the switch-to-FIFO push controller: FSM encoding,
// default debounce length and switch data width.
package fifo_sw_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;
  localparam int unsigned DATA_W              = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HELD  = 2'd2
  } state_e;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizers for the push button and data switches, followed by
// a consecutive-mismatch debouncer that produces the stable button level.
module btn_debounce
  import fifo_sw_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_raw,
  input  logic [DATA_W-1:0] sw_raw,
  output logic              btn_stable,
  output logic [DATA_W-1:0] sw_sync
);

  localparam int unsigned       CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]        btn_sync_q;
  logic [DATA_W-1:0] sw_meta_q;
  logic [DATA_W-1:0] sw_sync_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              stable_q, stable_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_sync_q <= '0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
    end else begin
      btn_sync_q <= {btn_sync_q[0], btn_raw};
      sw_meta_q  <= sw_raw;
      sw_sync_q  <= sw_meta_q;
    end
  end

  // The counter holds mismatches seen so far; the mismatch that would make
  // it reach DEBOUNCE_CYCLES flips the stable level instead.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (btn_sync_q[1] == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = btn_sync_q[1];
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign btn_stable = stable_q;
  assign sw_sync    = sw_sync_q;

endmodule

// File: rtl/switch_push_ctrl.sv
// Turns a debounced push-button press into one FIFO write of the switch
// value, or an overflow pulse when the FIFO is full at decision time.
module switch_push_ctrl
  import fifo_sw_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic              WR_CLK,
  input  logic              rst,
  input  logic              BTN_PUSH,
  input  logic [DATA_W-1:0] SW,
  input  logic              Full,
  output logic              push,
  output logic [DATA_W-1:0] Data_In,
  output logic              Overflow,
  output logic [3:0]        Drop_Count,
  output logic [7:0]        Push_Count
);

  logic              btn_stable;
  logic [DATA_W-1:0] sw_sync;

  state_e            state_q, state_d;
  logic              push_q, push_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [3:0]        drop_q, drop_d;
  logic [7:0]        pcnt_q, pcnt_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk        (WR_CLK),
    .rst        (rst),
    .btn_raw    (BTN_PUSH),
    .sw_raw     (SW),
    .btn_stable (btn_stable),
    .sw_sync    (sw_sync)
  );

  // IDLE is only re-entered once the stable level is low, so a high level
  // seen in IDLE is always a fresh rise. push_q is set on entry to ISSUE so
  // it is high exactly during the ISSUE cycle.
  always_comb begin
    state_d = state_q;
    push_d  = 1'b0;
    ovf_d   = 1'b0;
    data_d  = data_q;
    drop_d  = drop_q;
    pcnt_d  = pcnt_q;
    case (state_q)
      IDLE: begin
        if (btn_stable) begin
          if (!Full) begin
            state_d = ISSUE;
            push_d  = 1'b1;
            data_d  = sw_sync;
            pcnt_d  = pcnt_q + 8'd1;
          end else begin
            state_d = HELD;
            ovf_d   = 1'b1;
            if (drop_q != '1) drop_d = drop_q + 4'd1;
          end
        end
      end
      ISSUE:   state_d = HELD;
      HELD:    if (!btn_stable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge WR_CLK or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      push_q  <= 1'b0;
      ovf_q   <= 1'b0;
      data_q  <= '0;
      drop_q  <= '0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      push_q  <= push_d;
      ovf_q   <= ovf_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign push       = push_q;
  assign Overflow   = ovf_q;
  assign Data_In    = data_q;
  assign Drop_Count = drop_q;
  assign Push_Count = pcnt_q;

endmodule

// File: tb/tb_switch_push_ctrl.sv
// Directed self-checking bench for switch_push_ctrl with DEBOUNCE_CYCLES=4.
module tb_switch_push_ctrl;

  localparam int unsigned DEB = 4;
  localparam int          LAT = DEB + 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn;
  logic       full;
  logic [3:0] sw;
  logic       push;
  logic [3:0] data_in;
  logic       ovf;
  logic [3:0] drop_cnt;
  logic [7:0] push_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  switch_push_ctrl #(
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .WR_CLK     (clk),
    .rst        (rst),
    .BTN_PUSH   (btn),
    .SW         (sw),
    .Full       (full),
    .push       (push),
    .Data_In    (data_in),
    .Overflow   (ovf),
    .Drop_Count (drop_cnt),
    .Push_Count (push_cnt)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Holds the button for 'hold' edges (edge 1 = first edge sampling it high),
  // optionally changes SW after edge chg_edge, then releases and lets it settle.
  task automatic run_press(input logic [3:0] sw0, input logic [3:0] sw1,
                           input int chg_edge, input int hold,
                           output int push_edge, output int ovf_edge,
                           output int npush, output int novf,
                           output logic [3:0] data_at_push);
    push_edge = 0; ovf_edge = 0; npush = 0; novf = 0; data_at_push = '0;
    @(negedge clk);
    sw  = sw0;
    btn = 1'b1;
    for (int e = 1; e <= hold; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (push) begin
        npush++;
        if (push_edge == 0) begin push_edge = e; data_at_push = data_in; end
      end
      if (ovf) begin
        novf++;
        if (ovf_edge == 0) ovf_edge = e;
      end
      if (e == chg_edge) sw = sw1;
    end
    btn = 1'b0;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (push) npush++;
      if (ovf)  novf++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; btn = 1'b0; sw = 4'h0; full = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (push !== 1'b0)      begin failures++; $display("FAIL reset_push got=%0b exp=0", push); end
    checks++; if (ovf !== 1'b0)       begin failures++; $display("FAIL reset_ovf got=%0b exp=0", ovf); end
    checks++; if (data_in !== 4'h0)   begin failures++; $display("FAIL reset_data got=%h exp=0", data_in); end
    checks++; if (drop_cnt !== 4'h0)  begin failures++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
    checks++; if (push_cnt !== 8'h00) begin failures++; $display("FAIL reset_pcnt got=%0d exp=0", push_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_press;
    int pe, oe, np, no;
    logic [3:0] d;
    run_press(4'hA, 4'hA, 0, 20, pe, oe, np, no, d);
    checks++; if (np != 1)            begin failures++; $display("FAIL press_npush got=%0d exp=1", np); end
    checks++; if (pe != LAT)          begin failures++; $display("FAIL press_latency got=%0d exp=%0d", pe, LAT); end
    checks++; if (d !== 4'hA)         begin failures++; $display("FAIL press_data got=%h exp=a", d); end
    checks++; if (push_cnt !== 8'd1)  begin failures++; $display("FAIL press_pcnt got=%0d exp=1", push_cnt); end
    checks++; if (no != 0)            begin failures++; $display("FAIL press_novf got=%0d exp=0", no); end
  endtask

  task automatic test_bounce;
    int pe, oe, np, no;
    int bp = 0, bo = 0;
    logic [3:0] d;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (push) bp++;
        if (ovf)  bo++;
        btn = (c != 3);
      end
    end
    checks++; if (bp != 0)            begin failures++; $display("FAIL bounce_push got=%0d exp=0", bp); end
    checks++; if (bo != 0)            begin failures++; $display("FAIL bounce_ovf got=%0d exp=0", bo); end
    checks++; if (push_cnt !== 8'd1)  begin failures++; $display("FAIL bounce_pcnt got=%0d exp=1", push_cnt); end
    run_press(4'h5, 4'h5, 0, 20, pe, oe, np, no, d);
    checks++; if (np != 1)            begin failures++; $display("FAIL bounce_clean_npush got=%0d exp=1", np); end
    checks++; if (pe != LAT)          begin failures++; $display("FAIL bounce_clean_latency got=%0d exp=%0d", pe, LAT); end
    checks++; if (d !== 4'h5)         begin failures++; $display("FAIL bounce_clean_data got=%h exp=5", d); end
    checks++; if (push_cnt !== 8'd2)  begin failures++; $display("FAIL bounce_clean_pcnt got=%0d exp=2", push_cnt); end
  endtask

  task automatic test_sw_change;
    int pe, oe, np, no;
    logic [3:0] d;
    run_press(4'h3, 4'hC, LAT, 20, pe, oe, np, no, d);
    checks++; if (pe != LAT)          begin failures++; $display("FAIL swchg_latency got=%0d exp=%0d", pe, LAT); end
    checks++; if (d !== 4'h3)         begin failures++; $display("FAIL swchg_data_at_push got=%h exp=3", d); end
    checks++; if (data_in !== 4'h3)   begin failures++; $display("FAIL swchg_data_hold got=%h exp=3", data_in); end
    checks++; if (push_cnt !== 8'd3)  begin failures++; $display("FAIL swchg_pcnt got=%0d exp=3", push_cnt); end
  endtask

  task automatic test_full;
    int pe, oe, np, no;
    int tot_p, tot_o;
    logic [3:0] d;
    full = 1'b1;
    run_press(4'h6, 4'h6, 0, 20, pe, oe, np, no, d);
    checks++; if (np != 0)            begin failures++; $display("FAIL full_npush got=%0d exp=0", np); end
    checks++; if (no != 1)            begin failures++; $display("FAIL full_novf got=%0d exp=1", no); end
    checks++; if (oe != LAT)          begin failures++; $display("FAIL full_ovf_latency got=%0d exp=%0d", oe, LAT); end
    checks++; if (drop_cnt !== 4'd1)  begin failures++; $display("FAIL full_drop1 got=%0d exp=1", drop_cnt); end
    tot_p = np; tot_o = no;
    for (int i = 2; i <= 16; i++) begin
      run_press(4'h6, 4'h6, 0, 10, pe, oe, np, no, d);
      tot_p += np; tot_o += no;
      if (i == 15) begin
        checks++; if (drop_cnt !== 4'd15) begin failures++; $display("FAIL full_drop15 got=%0d exp=15", drop_cnt); end
      end
    end
    checks++; if (drop_cnt !== 4'd15) begin failures++; $display("FAIL full_drop_sat got=%0d exp=15", drop_cnt); end
    checks++; if (tot_o != 16)        begin failures++; $display("FAIL full_total_ovf got=%0d exp=16", tot_o); end
    checks++; if (tot_p != 0)         begin failures++; $display("FAIL full_total_push got=%0d exp=0", tot_p); end
    checks++; if (push_cnt !== 8'd3)  begin failures++; $display("FAIL full_pcnt got=%0d exp=3", push_cnt); end
    full = 1'b0;
  endtask

  task automatic test_reset_mid;
    int pe = 0, np = 0;
    @(negedge clk);
    sw  = 4'h9;
    btn = 1'b1;
    for (int e = 1; e <= LAT; e++) begin @(posedge clk); @(negedge clk); end
    checks++; if (push !== 1'b1)      begin failures++; $display("FAIL rmid_issue_push got=%0b exp=1", push); end
    #1 rst = 1'b1;
    #1;
    checks++; if (push !== 1'b0)      begin failures++; $display("FAIL rmid_push got=%0b exp=0", push); end
    checks++; if (push_cnt !== 8'd0)  begin failures++; $display("FAIL rmid_pcnt got=%0d exp=0", push_cnt); end
    checks++; if (drop_cnt !== 4'd0)  begin failures++; $display("FAIL rmid_drop got=%0d exp=0", drop_cnt); end
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (push) begin np++; if (pe == 0) pe = e; end
    end
    btn = 1'b0;
    repeat (12) begin @(posedge clk); @(negedge clk); if (push) np++; end
    checks++; if (np != 1)            begin failures++; $display("FAIL rmid_npush got=%0d exp=1", np); end
    checks++; if (pe != LAT)          begin failures++; $display("FAIL rmid_latency got=%0d exp=%0d", pe, LAT); end
    checks++; if (push_cnt !== 8'd1)  begin failures++; $display("FAIL rmid_pcnt_after got=%0d exp=1", push_cnt); end
  endtask

  task automatic test_wrap;
    int pe, oe, np, no;
    int tot_p = 0, tot_o = 0;
    logic [3:0] d;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 256; i++) begin
      run_press(4'(i), 4'(i), 0, 10, pe, oe, np, no, d);
      tot_p += np; tot_o += no;
      if (i == 255) begin
        checks++; if (push_cnt !== 8'd255) begin failures++; $display("FAIL wrap_pcnt255 got=%0d exp=255", push_cnt); end
      end
    end
    checks++; if (push_cnt !== 8'd0)  begin failures++; $display("FAIL wrap_pcnt got=%0d exp=0", push_cnt); end
    checks++; if (tot_p != 256)       begin failures++; $display("FAIL wrap_total_push got=%0d exp=256", tot_p); end
    checks++; if (tot_o != 0)         begin failures++; $display("FAIL wrap_total_ovf got=%0d exp=0", tot_o); end
    checks++; if (data_in !== 4'h0)   begin failures++; $display("FAIL wrap_last_data got=%h exp=0", data_in); end
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_sw_change();
    test_full();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/switch_push_ctrl.md
SWITCH_PUSH_CTRL -- requirements
Module: switch_push_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, consecutive stable cycles required to accept a button level change; legal range 2..65535.
REQ-002 WR_CLK  input  1  single clock; this is the FIFO write-side clock domain.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 BTN_PUSH  input  1  raw, asynchronous, bouncing push button; high = pressed.
REQ-005 SW  input  4  raw, asynchronous data switches.
REQ-006 Full  input  1  FIFO full flag, synchronous to WR_CLK.
REQ-007 push  output  1  single-cycle FIFO write strobe.
REQ-008 Data_In  output  4  FIFO write data, valid whenever push is high.
REQ-009 Overflow  output  1  single-cycle pulse; a press was rejected because Full was high.
REQ-010 Drop_Count  output  4  number of rejected presses, saturating at 15.
REQ-011 Push_Count  output  8  number of accepted presses, wrapping modulo 256.

Function
REQ-012 BTN_PUSH and each SW bit SHALL pass through a two-flop synchronizer before any other use.
REQ-013 Debounce: the counter increments each cycle the synchronized button differs from the stable level and clears on any cycle they match.
REQ-014 When the counter has recorded DEBOUNCE_CYCLES consecutive mismatch cycles, the stable level SHALL take the synchronized value on that edge and the counter SHALL clear.
REQ-015 FSM states SHALL be IDLE, ISSUE and HELD; encoding SHALL come from the shared package.
REQ-016 IDLE to ISSUE on a stable-level rise when Full=0; Data_In SHALL be latched from the synchronized SW on that same edge.
REQ-017 IDLE to HELD on a stable-level rise when Full=1; Overflow SHALL pulse for one cycle and Drop_Count SHALL increment unless already 15.
REQ-018 ISSUE SHALL drive push=1 for exactly one cycle, increment Push_Count, and transition unconditionally to HELD.
REQ-019 HELD to IDLE when the stable level is 0; there SHALL be at most one push or one Overflow per debounced press.
REQ-020 Full SHALL be sampled only at the IDLE decision edge; Full rising while in ISSUE SHALL NOT cancel the push.
REQ-021 Total latency: push is high in the cycle following rising edge number DEBOUNCE_CYCLES+3, counting the first edge that samples BTN_PUSH high as edge 1.
REQ-022 Switch changes after the latch edge SHALL NOT alter Data_In until the next accepted press.
REQ-023 Bounces shorter than DEBOUNCE_CYCLES cycles SHALL produce no push, no Overflow, and no counter change.
REQ-024 push, Overflow and all counters SHALL be registered outputs, with no combinational path from any input.

Reset
REQ-025 rst asynchronously clears the synchronizers, debounce counter, stable level (0), FSM state (IDLE), push, Overflow, Data_In, Drop_Count and Push_Count to 0.
REQ-026 Reset asserted mid-press SHALL abort any pending push; a button still held after reset release SHALL be re-debounced and produce one push.

Structure
REQ-027 Package fifo_sw_pkg SHALL hold the FSM state typedef and encoding, the DEBOUNCE_CYCLES default, and the data width constant (4).
REQ-028 The synchronizer and debounce logic SHALL live in one sub-module, btn_debounce, parameterized by DEBOUNCE_CYCLES.
REQ-029 The debounce counter width SHALL be derived from DEBOUNCE_CYCLES by ceiling log2.

Verification
REQ-030 Press with DEBOUNCE_CYCLES=4, SW=4'hA, Full=0, held 20 cycles -> exactly one push, in the cycle after edge 7, Data_In=4'hA, Push_Count=1.
REQ-031 Bounce of 3-cycle high pulses separated by 1-cycle lows, then a clean press -> exactly one push, timed from the clean press.
REQ-032 Full=1 during a press -> no push, one Overflow pulse, Drop_Count=1; sixteen such presses -> Drop_Count=15.
REQ-033 SW changed from 4'h3 to 4'hC one cycle after the latch edge -> Data_In=4'h3 at push.
REQ-034 rst pulsed while in ISSUE -> push=0 and Push_Count=0; button still held -> one push after DEBOUNCE_CYCLES+3 edges.
REQ-035 256 accepted presses -> Push_Count wraps to 0, with no Overflow.
